// File: rtl/sr_pkg.sv
// -----------------------------------------------------------------------------
// sr_pkg
// Shared types and constants for the SR pulse driver: FSM state encoding,
// default parameter values and counter widths sized for the parameter ranges.
// -----------------------------------------------------------------------------
package sr_pkg;

  // Default parameter values
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;
  localparam int unsigned DEF_PULSE_WIDTH     = 2;

  // Counter widths cover the full legal ranges (1..255 and 1..15)
  localparam int unsigned DEB_CNT_W   = 8;
  localparam int unsigned PULSE_CNT_W = 4;

  // Pulse FSM states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PULSE_S = 2'd1,
    PULSE_R = 2'd2
  } sr_state_t;

endpackage

// File: rtl/sr_debounce_ch.sv
// -----------------------------------------------------------------------------
// sr_debounce_ch
// One push-button channel: 2-flop synchronizer, debounce counter producing a
// stable level, and a one-cycle request on each 0->1 change of that level.
//
// Ports:
//   i_clk   - clock
//   i_rst   - asynchronous active-high reset
//   i_btn   - raw, asynchronous, bouncy button input
//   o_rise  - one-cycle request, high the cycle after the stable level rises
// -----------------------------------------------------------------------------
module sr_debounce_ch
  import sr_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_rise
);

  // The count reaching DEBOUNCE_CYCLES corresponds to the counter holding
  // DEBOUNCE_CYCLES-1 on a cycle that still disagrees.
  localparam logic [DEB_CNT_W-1:0] CNT_LAST = DEB_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic                 r_sync1;
  logic                 r_sync2;
  logic                 r_stable;
  logic                 r_rise;
  logic [DEB_CNT_W-1:0] r_cnt;

  // Two-flop synchronizer for the asynchronous button
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce counter and stable level; the request is registered on the
  // same edge the stable level rises.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_stable <= 1'b0;
      r_cnt    <= '0;
      r_rise   <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_stable <= ~r_stable;
        r_cnt    <= '0;
        r_rise   <= ~r_stable;
      end else begin
        r_cnt <= r_cnt + DEB_CNT_W'(1);
      end
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/sr_pulse_driver.sv
// -----------------------------------------------------------------------------
// sr_pulse_driver
// Debounces set/reset push-buttons and drives fixed-width S/R pulses to a
// downstream SR latch, keeping a registered model of the latch state.
//
// Ports:
//   clk       - sole clock, rising edge
//   reset     - asynchronous active-high reset
//   set_btn   - raw bouncy set button
//   reset_btn - raw bouncy reset button
//   S         - set pulse, PULSE_WIDTH cycles per accepted set request
//   R         - reset pulse, PULSE_WIDTH cycles per accepted reset request
//   Q         - registered latch state model
//   Qbar      - complement of Q
//   conflict  - one-cycle flag when set and reset requests coincide in IDLE
// -----------------------------------------------------------------------------
module sr_pulse_driver
  import sr_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned PULSE_WIDTH     = DEF_PULSE_WIDTH
) (
  input  logic clk,
  input  logic reset,
  input  logic set_btn,
  input  logic reset_btn,
  output logic S,
  output logic R,
  output logic Q,
  output logic Qbar,
  output logic conflict
);

  // Counter counts down to zero, so a pulse spans PULSE_WIDTH cycles
  localparam logic [PULSE_CNT_W-1:0] PCNT_LOAD = PULSE_CNT_W'(PULSE_WIDTH - 1);

  logic w_set_req;
  logic w_reset_req;

  sr_state_t              r_state;
  logic [PULSE_CNT_W-1:0] r_pcnt;
  logic                   r_s;
  logic                   r_r;
  logic                   r_q;
  logic                   r_qbar;
  logic                   r_conflict;

  // Button channels
  sr_debounce_ch #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_set_ch (
    .i_clk  (clk),
    .i_rst  (reset),
    .i_btn  (set_btn),
    .o_rise (w_set_req)
  );

  sr_debounce_ch #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_reset_ch (
    .i_clk  (clk),
    .i_rst  (reset),
    .i_btn  (reset_btn),
    .o_rise (w_reset_req)
  );

  // Pulse FSM with registered outputs; requests outside IDLE are dropped
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_pcnt     <= '0;
      r_s        <= 1'b0;
      r_r        <= 1'b0;
      r_q        <= 1'b0;
      r_qbar     <= 1'b1;
      r_conflict <= 1'b0;
    end else begin
      r_conflict <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_set_req && w_reset_req) begin
            r_conflict <= 1'b1;
          end else if (w_set_req) begin
            r_state <= PULSE_S;
            r_s     <= 1'b1;
            r_q     <= 1'b1;
            r_qbar  <= 1'b0;
            r_pcnt  <= PCNT_LOAD;
          end else if (w_reset_req) begin
            r_state <= PULSE_R;
            r_r     <= 1'b1;
            r_q     <= 1'b0;
            r_qbar  <= 1'b1;
            r_pcnt  <= PCNT_LOAD;
          end
        end
        PULSE_S: begin
          if (r_pcnt == '0) begin
            r_state <= IDLE;
            r_s     <= 1'b0;
          end else begin
            r_pcnt <= r_pcnt - PULSE_CNT_W'(1);
          end
        end
        PULSE_R: begin
          if (r_pcnt == '0) begin
            r_state <= IDLE;
            r_r     <= 1'b0;
          end else begin
            r_pcnt <= r_pcnt - PULSE_CNT_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_s     <= 1'b0;
          r_r     <= 1'b0;
        end
      endcase
    end
  end

  assign S        = r_s;
  assign R        = r_r;
  assign Q        = r_q;
  assign Qbar     = r_qbar;
  assign conflict = r_conflict;

endmodule

// File: tb/tb_sr_pulse_driver.sv
// -----------------------------------------------------------------------------
// tb_sr_pulse_driver
// Directed scenarios for sr_pulse_driver. A behavioural model derives the
// expected outputs from the recorded button samples using edge arithmetic,
// and every cycle the DUT outputs are compared against it.
// -----------------------------------------------------------------------------
module tb_sr_pulse_driver;

  localparam int D    = 4;
  localparam int PW   = 2;
  localparam int MAXE = 1023;

  logic clk = 1'b0;
  logic reset;
  logic set_btn;
  logic reset_btn;
  logic S, R, Q, Qbar, conflict;

  sr_pulse_driver #(
    .DEBOUNCE_CYCLES(D),
    .PULSE_WIDTH    (PW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .set_btn  (set_btn),
    .reset_btn(reset_btn),
    .S        (S),
    .R        (R),
    .Q        (Q),
    .Qbar     (Qbar),
    .conflict (conflict)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Model state: edge index since reset release, sampled button history
  int edge_cnt;
  bit hist[2][MAXE+1];
  bit m_stable[2];
  int m_last_flip[2];
  bit m_rose[2];
  int pulse_end;
  int pulse_kind;   // 0 none, 1 set pulse, 2 reset pulse
  bit exp_s, exp_r, exp_q, exp_conf;

  // Observed-output tallies for the literal scenario checks
  int s_cycles, r_cycles, conf_cycles, first_s, first_r;

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (edge %0d, t=%0t)", name, act, exp, edge_cnt, $time);
    end
  endtask

  // Level seen by the debounce logic at edge k: the button sampled two edges earlier
  function automatic bit synced(int ch, int k);
    if (k - 2 >= 1) return hist[ch][k-2];
    return 1'b0;
  endfunction

  task automatic model_reset();
    edge_cnt   = 0;
    pulse_end  = -100;
    pulse_kind = 0;
    exp_s = 0; exp_r = 0; exp_q = 0; exp_conf = 0;
    for (int ch = 0; ch < 2; ch++) begin
      m_stable[ch]    = 0;
      m_last_flip[ch] = 0;
      m_rose[ch]      = 0;
    end
  endtask

  task automatic model_step();
    int n;
    bit rs, rr, all_diff;
    edge_cnt++;
    n = edge_cnt;
    if (n > MAXE) begin
      $display("FAIL edge_budget: got %0d expected at most %0d", n, MAXE);
      $fatal(1);
    end
    hist[0][n] = set_btn;
    hist[1][n] = reset_btn;
    rs = m_rose[0];
    rr = m_rose[1];
    exp_conf = 0;
    // A pulse started at edge a occupies edges a..a+PW; idle only after that
    if (n > pulse_end) begin
      if (rs && rr) exp_conf = 1;
      else if (rs) begin pulse_kind = 1; pulse_end = n + PW; exp_q = 1; end
      else if (rr) begin pulse_kind = 2; pulse_end = n + PW; exp_q = 0; end
    end
    exp_s = (pulse_kind == 1) && (n < pulse_end);
    exp_r = (pulse_kind == 2) && (n < pulse_end);
    // Stable level flips once D consecutive post-flip samples disagree with it
    for (int ch = 0; ch < 2; ch++) begin
      m_rose[ch] = 0;
      if (n - D >= m_last_flip[ch]) begin
        all_diff = 1;
        for (int k = n - D + 1; k <= n; k++)
          if (synced(ch, k) == m_stable[ch]) all_diff = 0;
        if (all_diff) begin
          m_stable[ch]    = ~m_stable[ch];
          m_last_flip[ch] = n;
          m_rose[ch]      = m_stable[ch];
        end
      end
    end
  endtask

  task automatic compare_all();
    check("S",        int'(S),        int'(exp_s));
    check("R",        int'(R),        int'(exp_r));
    check("Q",        int'(Q),        int'(exp_q));
    check("Qbar",     int'(Qbar),     int'(!exp_q));
    check("conflict", int'(conflict), int'(exp_conf));
    if (S === 1'b1) begin s_cycles++; if (first_s < 0) first_s = edge_cnt; end
    if (R === 1'b1) begin r_cycles++; if (first_r < 0) first_r = edge_cnt; end
    if (conflict === 1'b1) conf_cycles++;
  endtask

  task automatic clear_mon();
    s_cycles = 0; r_cycles = 0; conf_cycles = 0; first_s = -1; first_r = -1;
  endtask

  // One clock: model on the edge, compare 1ns later, return at the falling edge
  task automatic tick();
    @(posedge clk);
    if (!reset) model_step();
    #1;
    compare_all();
    @(negedge clk);
  endtask

  // Async reset applied between edges and checked before the next edge
  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check("rst_S",    int'(S),        0);
    check("rst_R",    int'(R),        0);
    check("rst_Q",    int'(Q),        0);
    check("rst_Qbar", int'(Qbar),     1);
    check("rst_conf", int'(conflict), 0);
    @(negedge clk);
    tick();
    tick();
    reset = 1'b0;
    clear_mon();
  endtask

  int e0;

  initial begin
    reset     = 1'b1;
    set_btn   = 1'b0;
    reset_btn = 1'b0;
    clear_mon();
    model_reset();
    @(negedge clk);

    // Clean set press: S after edges 7 and 8, Q=1 from edge 7
    do_reset();
    set_btn = 1'b1;
    repeat (12) tick();
    check("s1_first_s", first_s, 7);
    check("s1_s_cycles", s_cycles, 2);
    check("s1_Q", int'(Q), 1);
    check("s1_Qbar", int'(Qbar), 0);
    check("s1_model_q", int'(exp_q), 1);

    // Reset press after set: two R cycles, Q cleared, no S
    clear_mon();
    e0 = edge_cnt;
    reset_btn = 1'b1;
    repeat (12) tick();
    check("s2_first_r", first_r, e0 + 7);
    check("s2_r_cycles", r_cycles, 2);
    check("s2_s_cycles", s_cycles, 0);
    check("s2_Q", int'(Q), 0);
    check("s2_Qbar", int'(Qbar), 1);
    set_btn   = 1'b0;
    reset_btn = 1'b0;
    repeat (10) tick();

    // Bounce: 3-cycle highs never accepted
    do_reset();
    repeat (5) begin
      set_btn = 1'b1;
      repeat (3) tick();
      set_btn = 1'b0;
      repeat (3) tick();
    end
    repeat (8) tick();
    check("s3_s_cycles", s_cycles, 0);
    check("s3_Q", int'(Q), 0);

    // Simultaneous presses after Q=1: one conflict cycle, Q held
    do_reset();
    set_btn = 1'b1;
    repeat (12) tick();
    set_btn = 1'b0;
    repeat (10) tick();
    clear_mon();
    set_btn   = 1'b1;
    reset_btn = 1'b1;
    repeat (12) tick();
    check("s4_conf_cycles", conf_cycles, 1);
    check("s4_s_cycles", s_cycles, 0);
    check("s4_r_cycles", r_cycles, 0);
    check("s4_Q", int'(Q), 1);
    set_btn   = 1'b0;
    reset_btn = 1'b0;
    repeat (10) tick();

    // Reset during first S cycle, set held: fresh pulse 7 edges after release
    do_reset();
    set_btn = 1'b1;
    repeat (7) tick();
    check("s5_S_before_rst", int'(S), 1);
    do_reset();
    repeat (10) tick();
    check("s5_first_s", first_s, 7);
    check("s5_s_cycles", s_cycles, 2);
    set_btn = 1'b0;
    repeat (8) tick();

    // Reset request landing mid set pulse is dropped
    do_reset();
    set_btn = 1'b1;
    tick();
    reset_btn = 1'b1;
    repeat (14) tick();
    check("s6_s_cycles", s_cycles, 2);
    check("s6_r_cycles", r_cycles, 0);
    check("s6_Q", int'(Q), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
